// File: rtl/pwm_pkg.sv
// pwm_pkg: widths, limits, state encoding and duty helpers
// shared by the PWM duty scheduler and its period counter.
package pwm_pkg;

  localparam int PERIOD_BITS = 12;
  localparam int DUTY_W      = 15;
  localparam int PID_W       = 16;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 15'd30000;
  localparam logic [DUTY_W-1:0] SS_STEP  = 15'd256;
  localparam logic [DUTY_W-1:0] MAX_STEP = 15'd1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOFT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Negative samples clamp to 0, large ones to DUTY_MAX.
  function automatic logic [DUTY_W-1:0] sat(
    input logic [PID_W-1:0] u
  );
    logic [DUTY_W-1:0] r;
    if (u[PID_W-1])
      r = '0;
    else if (u[PID_W-2:0] > DUTY_MAX)
      r = DUTY_MAX;
    else
      r = u[DUTY_W-1:0];
    return r;
  endfunction

  function automatic logic [DUTY_W-1:0] slew(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    logic signed [DUTY_W:0] diff;
    logic signed [DUTY_W:0] lim;
    logic [DUTY_W-1:0]      r;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    lim  = $signed({1'b0, MAX_STEP});
    if (diff > lim)
      r = cur + MAX_STEP;
    else if (diff < -lim)
      r = cur - MAX_STEP;
    else
      r = tgt;
    return r;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running phase counter that resets to
// all ones, so o_tick is high in the first cycle after reset.
module pwm_period_counter #(
  parameter int BITS = 12
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  logic [BITS-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '1;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_tick = &r_cnt;

endmodule

// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler: saturates PID samples and applies them to
// the PWM duty word at period wrap, with soft start and slewing.
module pwm_duty_scheduler #(
  parameter int PERIOD_BITS = pwm_pkg::PERIOD_BITS
) (
  input  logic                        clk1,
  input  logic                        arst_n,
  input  logic                        enable,
  input  logic                        fault,
  input  logic                        pid_valid,
  input  logic [pwm_pkg::PID_W-1:0]   pid_u,
  output logic                        pid_ready,
  output logic [pwm_pkg::DUTY_W-1:0]  duty,
  output logic                        period_tick,
  output logic [1:0]                  state,
  output logic                        overrun
);

  import pwm_pkg::*;

  state_e              r_state;
  state_e              w_state_n;
  logic [DUTY_W-1:0]   r_duty;
  logic [DUTY_W-1:0]   w_duty_n;
  logic [DUTY_W-1:0]   r_target;
  logic                r_pending;
  logic                r_overrun;
  logic                w_tick;
  logic                w_accept;
  logic                w_enter;
  logic [DUTY_W:0]     w_ss_sum;

  pwm_period_counter #(
    .BITS (PERIOD_BITS)
  ) u_cnt (
    .i_clk   (clk1),
    .i_rst_n (arst_n),
    .o_tick  (w_tick)
  );

  assign pid_ready = (r_state == ST_SOFT) ||
                     (r_state == ST_RUN);
  assign w_accept  = pid_valid && pid_ready;
  assign w_ss_sum  = {1'b0, r_duty} + {1'b0, SS_STEP};

  always_comb begin
    w_state_n = r_state;
    w_duty_n  = r_duty;
    w_enter   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_duty_n = '0;
        if (enable && !fault) begin
          w_state_n = ST_SOFT;
          w_enter   = 1'b1;
        end
      end
      ST_SOFT: begin
        if (fault) begin
          w_state_n = ST_FAULT;
          w_duty_n  = '0;
        end else if (!enable) begin
          w_state_n = ST_IDLE;
          w_duty_n  = '0;
        end else if (w_tick) begin
          if (w_ss_sum >= {1'b0, r_target}) begin
            w_duty_n  = r_target;
            w_state_n = ST_RUN;
          end else begin
            w_duty_n = w_ss_sum[DUTY_W-1:0];
          end
        end
      end
      ST_RUN: begin
        if (fault) begin
          w_state_n = ST_FAULT;
          w_duty_n  = '0;
        end else if (!enable) begin
          w_state_n = ST_IDLE;
          w_duty_n  = '0;
        end else if (w_tick) begin
          w_duty_n = slew(r_duty, r_target);
        end
      end
      ST_FAULT: begin
        w_duty_n = '0;
        if (!enable && !fault)
          w_state_n = ST_IDLE;
      end
      default: begin
        w_state_n = ST_IDLE;
        w_duty_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
    end else begin
      r_state <= w_state_n;
      r_duty  <= w_duty_n;
    end
  end

  // A tick that coincides with an accept uses the old target.
  always_ff @(posedge clk1 or negedge arst_n) begin
    if (!arst_n) begin
      r_target  <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_enter) begin
        r_target  <= '0;
        r_pending <= 1'b0;
      end else if (w_accept) begin
        r_target  <= sat(pid_u);
        r_pending <= 1'b1;
      end else if (w_tick) begin
        r_pending <= 1'b0;
      end
      if (r_state == ST_IDLE)
        r_overrun <= 1'b0;
      else if (w_accept && r_pending && !w_tick)
        r_overrun <= 1'b1;
    end
  end

  assign duty        = r_duty;
  assign period_tick = w_tick;
  assign state       = r_state;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// tb_pwm_duty_scheduler: directed sequences, a saturation table and
// random stimulus checked against an arithmetic reference model.
module tb_pwm_duty_scheduler;

  localparam int PB  = 6;
  localparam int PER = 1 << PB;

  logic        clk1 = 1'b0;
  logic        arst_n = 1'b1;
  logic        enable = 1'b0;
  logic        fault = 1'b0;
  logic        pid_valid = 1'b0;
  logic [15:0] pid_u = '0;
  logic        pid_ready;
  logic [14:0] duty;
  logic        period_tick;
  logic [1:0]  state;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int m_phase, m_duty, m_state, m_target;
  bit m_pend, m_ovr;

  typedef struct {
    logic [15:0] u;
    int          exp_duty;
  } vec_t;

  vec_t tbl[10];

  pwm_duty_scheduler #(
    .PERIOD_BITS (PB)
  ) dut (
    .clk1        (clk1),
    .arst_n      (arst_n),
    .enable      (enable),
    .fault       (fault),
    .pid_valid   (pid_valid),
    .pid_u       (pid_u),
    .pid_ready   (pid_ready),
    .duty        (duty),
    .period_tick (period_tick),
    .state       (state),
    .overrun     (overrun)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int satm(input logic [15:0] u);
    int v;
    v = $signed(u);
    if (v < 0) return 0;
    if (v > 30000) return 30000;
    return v;
  endfunction

  function automatic int clampi(input int v, input int lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_reset();
    m_phase  = PER - 1;
    m_duty   = 0;
    m_state  = 0;
    m_target = 0;
    m_pend   = 0;
    m_ovr    = 0;
  endtask

  task automatic model_step();
    bit tick, acc, np, no;
    int nd, ns, nt;
    tick = (m_phase == PER - 1);
    acc  = pid_valid && (m_state == 1 || m_state == 2);
    nd = m_duty; ns = m_state; nt = m_target;
    np = m_pend; no = m_ovr;
    if (acc) begin
      nt = satm(pid_u);
      np = 1;
      if (m_pend && !tick) no = 1;
    end else if (tick) begin
      np = 0;
    end
    if (m_state == 0) no = 0;
    case (m_state)
      0: begin
        nd = 0;
        if (enable && !fault) begin
          ns = 1; nt = 0; np = 0;
        end
      end
      1, 2: begin
        if (fault) begin
          ns = 3; nd = 0;
        end else if (!enable) begin
          ns = 0; nd = 0;
        end else if (tick && m_state == 1) begin
          if (m_duty + 256 >= m_target) begin
            nd = m_target; ns = 2;
          end else begin
            nd = m_duty + 256;
          end
        end else if (tick) begin
          nd = m_duty + clampi(m_target - m_duty, 1024);
        end
      end
      default: begin
        nd = 0;
        if (!enable && !fault) ns = 0;
      end
    endcase
    m_duty = nd; m_state = ns; m_target = nt;
    m_pend = np; m_ovr = no;
    m_phase = (m_phase + 1) % PER;
  endtask

  task automatic check_cycle();
    int e;
    bit rdy;
    rdy = (m_state == 1 || m_state == 2);
    e = (m_duty << 5) | (m_state << 3) | (int'(rdy) << 2)
      | (int'(m_ovr) << 1) | int'(m_phase == PER - 1);
    chk("cycle{duty,state,rdy,ovr,tick}",
        {12'd0, duty, state, pid_ready, overrun, period_tick}, e);
  endtask

  task automatic cycle();
    @(posedge clk1);
    model_step();
    @(negedge clk1);
    check_cycle();
  endtask

  task automatic do_reset();
    #2 arst_n = 1'b0;
    #1;
    chk("rst duty", duty, 0);
    chk("rst state", state, 0);
    chk("rst ready", pid_ready, 0);
    chk("rst overrun", overrun, 0);
    model_reset();
    @(negedge clk1);
    arst_n = 1'b1;
    #1 chk("first tick", period_tick, 1);
  endtask

  task automatic run_to_tick();
    bit hit;
    hit = 0;
    for (int i = 0; i < PER + 2 && !hit; i++) begin
      hit = (m_phase == PER - 1);
      cycle();
    end
    chk("tick wait", hit, 1);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < PER + 2 && m_phase != p; i++)
      cycle();
    chk("phase wait", m_phase, p);
  endtask

  task automatic accept(input logic [15:0] u);
    pid_valid = 1'b1;
    pid_u     = u;
    cycle();
    pid_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{16'h8000, 0};
    tbl[1] = '{16'hFE0C, 0};
    tbl[2] = '{16'd8192, 8192};
    tbl[3] = '{16'd32000, 30000};
    tbl[4] = '{16'd30000, 30000};
    tbl[5] = '{16'd30001, 30000};
    tbl[6] = '{16'h7FFF, 30000};
    tbl[7] = '{16'd1, 1};
    tbl[8] = '{16'd12345, 12345};
    tbl[9] = '{16'd0, 0};

    model_reset();
    do_reset();
    for (int i = 0; i < 2 * PER; i++) cycle();

    do_reset();
    enable = 1'b1;
    cycle();
    chk("enter soft", state, 1);
    accept(16'd8192);
    for (int k = 1; k <= 32; k++) begin
      run_to_tick();
      chk("ss duty", duty, 256 * k);
      chk("ss state", state, (k == 32) ? 2 : 1);
    end

    accept(16'hFE0C);
    for (int k = 1; k <= 8; k++) begin
      run_to_tick();
      chk("slew down", duty, 8192 - 1024 * k);
    end

    accept(16'd32000);
    for (int k = 1; k <= 30; k++) begin
      run_to_tick();
      chk("slew up", duty, (k < 30) ? 1024 * k : 30000);
    end

    accept(16'd1000);
    accept(16'd2000);
    chk("overrun set", overrun, 1);
    for (int k = 0; k < 28; k++) run_to_tick();
    chk("latest wins", duty, 2000);
    enable = 1'b0;
    cycle();
    cycle();
    chk("ovr cleared", overrun, 0);

    enable = 1'b1;
    cycle();
    run_to_tick();
    chk("run at 0", state, 2);
    accept(16'd3000);
    wait_phase(PER - 1);
    accept(16'd500);
    chk("tick accept ovr", overrun, 0);
    chk("tick old target", duty, 1024);
    run_to_tick();
    chk("new target", duty, 500);

    wait_phase(30);
    fault = 1'b1;
    cycle();
    chk("fault duty", duty, 0);
    chk("fault state", state, 3);
    chk("fault ready", pid_ready, 0);
    fault = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("fault latched", state, 3);
    enable = 1'b0;
    cycle();
    chk("fault exit", state, 0);

    enable = 1'b1;
    cycle();
    run_to_tick();
    for (int v = 0; v < 10; v++) begin
      accept(tbl[v].u);
      for (int k = 0; k < 31; k++) run_to_tick();
      chk($sformatf("table[%0d]", v), duty, tbl[v].exp_duty);
    end

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 399) == 0) fault = ~fault;
      pid_valid = ($urandom_range(0, 19) == 0);
      pid_u = ($urandom_range(0, 1) == 1) ?
              16'($urandom) : 16'($urandom_range(0, 31000));
      if (i == 2000) do_reset();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
